audio_demux: RTL

AUDIO_DEMUX -- requirements
Module: audio_demux

---
 rtl/audio_pkg.sv | 27 ++
 rtl/audio_pair_fifo.sv | 65 ++++++
 rtl/audio_demux.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio demultiplexer: register map, control and
// status bit positions, and the playout state enumeration.
package audio_pkg;

  localparam logic [2:0] ADDR_L      = 3'd0;
  localparam logic [2:0] ADDR_R      = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_THRESH = 3'd3;
  localparam logic [2:0] ADDR_LEVEL  = 3'd4;
  localparam logic [2:0] ADDR_UCNT   = 3'd5;

  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_FLUSH_BIT  = 1;

  localparam int unsigned STAT_EMPTY_BIT = 0;
  localparam int unsigned STAT_FULL_BIT  = 1;
  localparam int unsigned STAT_OVF_BIT   = 2;
  localparam int unsigned STAT_UND_BIT   = 3;
  localparam int unsigned STAT_LEVEL_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } audio_state_e;

endpackage

// File: rtl/audio_pair_fifo.sv
// Synchronous FIFO of L/R sample pairs with show-ahead read data.
// Flush beats push and pop; a push into a full FIFO is accepted only when a
// pop happens in the same cycle, otherwise it is dropped and flagged.
module audio_pair_fifo import audio_pkg::*; #(
  parameter int unsigned FIFO_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 48
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [FIFO_WIDTH:0]   o_level,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_push_drop
);

  localparam int unsigned DEPTH = 1 << FIFO_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [FIFO_WIDTH-1:0] r_wr_ptr;
  logic [FIFO_WIDTH-1:0] r_rd_ptr;
  logic [FIFO_WIDTH:0]   r_level;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_do_pop;
  logic                  w_do_push;

  assign w_full      = (r_level == (FIFO_WIDTH+1)'(DEPTH));
  assign w_empty     = (r_level == '0);
  assign w_do_pop    = i_pop && !w_empty && !i_flush;
  assign w_do_push   = i_push && !i_flush && (!w_full || w_do_pop);
  assign o_push_drop = i_push && !i_flush && w_full && !w_do_pop;
  assign o_rdata     = r_mem[r_rd_ptr];
  assign o_level     = r_level;
  assign o_full      = w_full;
  assign o_empty     = w_empty;

  // pair storage; contents need no reset since the pointers gate every read
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // pointers wrap naturally; level tracks occupancy 0..DEPTH
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_level <= r_level + 1'b1;
      else if (w_do_pop && !w_do_push) r_level <= r_level - 1'b1;
    end
  end

endmodule

// File: rtl/audio_demux.sv
// Register-fed L/R sample FIFO played out on rising edges of an asynchronous
// I2S word clock. Optional build macro AUDIO_DEMUX_UNDERRUN_CNT_EN adds a
// 16-bit saturating underrun counter at address 5.
module audio_demux import audio_pkg::*; #(
  parameter int unsigned FIFO_WIDTH    = 6,
  parameter int unsigned AUD_BIT_DEPTH = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               address,
  input  logic                     read,
  input  logic                     write,
  input  logic [31:0]              datain,
  output logic [31:0]              dataout,
  input  logic                     lrck,
  output logic [AUD_BIT_DEPTH-1:0] l_sound_out,
  output logic [AUD_BIT_DEPTH-1:0] r_sound_out,
  output logic                     sample_valid,
  output logic                     refill_req,
  output logic                     underrun
);

  logic                       r_lrck_s1, r_lrck_s2, r_lrck_d;
  logic                       w_tick;
  logic [AUD_BIT_DEPTH-1:0]   r_stage_l, r_stage_r;
  logic                       r_push_pend;
  logic                       r_enable;
  logic [FIFO_WIDTH:0]        r_thresh;
  logic                       r_ovf_sticky, r_und_sticky;
  audio_state_e               r_state, w_state_next;
  logic [31:0]                r_dataout;
  logic [AUD_BIT_DEPTH-1:0]   r_l_out, r_r_out;
  logic                       r_sample_valid, r_underrun, r_refill;

  logic [AUD_BIT_DEPTH-1:0]   w_sample;
  logic                       w_wr_ctrl, w_flush;
  logic                       w_run_tick, w_pop, w_underrun_evt;
  logic [2*AUD_BIT_DEPTH-1:0] w_rdata_pair;
  logic [FIFO_WIDTH:0]        w_level;
  logic                       w_full, w_empty, w_push_drop;
  logic [31:0]                w_status, w_rdata;
  logic                       w_unused_datain;

  assign w_sample        = datain[31 -: AUD_BIT_DEPTH];
  assign w_wr_ctrl       = write && (address == ADDR_CTRL);
  assign w_flush         = w_wr_ctrl && datain[CTRL_FLUSH_BIT];
  assign w_tick          = r_lrck_s2 && !r_lrck_d;
  assign w_run_tick      = (r_state == ST_RUN) && r_enable && !w_flush && w_tick;
  assign w_pop           = w_run_tick && !w_empty;
  assign w_underrun_evt  = w_run_tick && w_empty;
  assign w_unused_datain = ^datain;

  assign dataout      = r_dataout;
  assign l_sound_out  = r_l_out;
  assign r_sound_out  = r_r_out;
  assign sample_valid = r_sample_valid;
  assign underrun     = r_underrun;
  assign refill_req   = r_refill;

  audio_pair_fifo #(
    .FIFO_WIDTH (FIFO_WIDTH),
    .DATA_WIDTH (2*AUD_BIT_DEPTH)
  ) u_fifo (
    .i_clk       (clk),
    .i_rst       (reset),
    .i_push      (r_push_pend),
    .i_pop       (w_pop),
    .i_flush     (w_flush),
    .i_wdata     ({r_stage_l, r_stage_r}),
    .o_rdata     (w_rdata_pair),
    .o_level     (w_level),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_push_drop (w_push_drop)
  );

  // two-flop synchroniser plus edge history for the word clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lrck_s1 <= 1'b0;
      r_lrck_s2 <= 1'b0;
      r_lrck_d  <= 1'b0;
    end else begin
      r_lrck_s1 <= lrck;
      r_lrck_s2 <= r_lrck_s1;
      r_lrck_d  <= r_lrck_s2;
    end
  end

  // Register writes. The R write stages the sample and the pair is pushed
  // from the staging registers one cycle later; flush acts in the cycle of
  // its own write, so a flush written right after an R write cancels that push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stage_l   <= '0;
      r_stage_r   <= '0;
      r_push_pend <= 1'b0;
      r_enable    <= 1'b0;
      r_thresh    <= '0;
    end else begin
      r_push_pend <= write && (address == ADDR_R);
      if (write && (address == ADDR_L))      r_stage_l <= w_sample;
      if (write && (address == ADDR_R))      r_stage_r <= w_sample;
      if (w_wr_ctrl)                         r_enable  <= datain[CTRL_ENABLE_BIT];
      if (write && (address == ADDR_THRESH)) r_thresh  <= datain[FIFO_WIDTH:0];
    end
  end

  // playout state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // next-state: disable dominates, then flush, then normal progression
  always_comb begin
    w_state_next = r_state;
    if (!r_enable) begin
      w_state_next = ST_IDLE;
    end else if (w_flush) begin
      w_state_next = ST_PRIME;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_next = ST_PRIME;
        ST_PRIME: if (w_level > r_thresh) w_state_next = ST_RUN;
        ST_RUN:   if (w_underrun_evt) w_state_next = ST_PRIME;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  // sample outputs: load on pop, zero on underrun or outside RUN, else hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_l_out        <= '0;
      r_r_out        <= '0;
      r_sample_valid <= 1'b0;
      r_underrun     <= 1'b0;
      r_refill       <= 1'b0;
    end else begin
      r_sample_valid <= w_run_tick;
      r_underrun     <= w_underrun_evt;
      r_refill       <= r_enable && (w_level <= r_thresh);
      if (w_pop) begin
        r_l_out <= w_rdata_pair[2*AUD_BIT_DEPTH-1 -: AUD_BIT_DEPTH];
        r_r_out <= w_rdata_pair[AUD_BIT_DEPTH-1:0];
      end else if (w_underrun_evt || (r_state != ST_RUN)) begin
        r_l_out <= '0;
        r_r_out <= '0;
      end
    end
  end

  // sticky error flags: a status read clears them, a same-cycle event wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf_sticky <= 1'b0;
      r_und_sticky <= 1'b0;
    end else begin
      if (w_push_drop)                             r_ovf_sticky <= 1'b1;
      else if (read && (address == ADDR_CTRL))     r_ovf_sticky <= 1'b0;
      if (w_underrun_evt)                          r_und_sticky <= 1'b1;
      else if (read && (address == ADDR_CTRL))     r_und_sticky <= 1'b0;
    end
  end

`ifdef AUDIO_DEMUX_UNDERRUN_CNT_EN
  logic [15:0] r_ucnt;

  // saturating underrun event count, cleared by a write to its address
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    r_ucnt <= '0;
    else if (write && (address == ADDR_UCNT))     r_ucnt <= '0;
    else if (w_underrun_evt && (r_ucnt != '1))    r_ucnt <= r_ucnt + 16'd1;
  end
`endif

  // status word assembly
  always_comb begin
    w_status                           = '0;
    w_status[STAT_LEVEL_LSB +: 8]      = 8'(w_level);
    w_status[STAT_UND_BIT]             = r_und_sticky;
    w_status[STAT_OVF_BIT]             = r_ovf_sticky;
    w_status[STAT_FULL_BIT]            = w_full;
    w_status[STAT_EMPTY_BIT]           = w_empty;
  end

  // read mux
  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_CTRL:   w_rdata = w_status;
      ADDR_THRESH: w_rdata = 32'(r_thresh);
      ADDR_LEVEL:  w_rdata = 32'(w_level);
`ifdef AUDIO_DEMUX_UNDERRUN_CNT_EN
      ADDR_UCNT:   w_rdata = 32'(r_ucnt);
`endif
      default:     w_rdata = '0;
    endcase
  end

  // read data is registered and presented the cycle after the strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r_dataout <= '0;
    else if (read) r_dataout <= w_rdata;
  end

endmodule
